// File: rtl/mips_mem_pkg.sv
// Shared constants for the MIPS memory responder: MMIO register offsets,
// STATUS bit positions and the address-region decode type.
package mips_mem_pkg;

  localparam logic [3:0] MMIO_CYCLE  = 4'h0;
  localparam logic [3:0] MMIO_OUT    = 4'h4;
  localparam logic [3:0] MMIO_STATUS = 4'h8;
  localparam logic [3:0] MMIO_CMP    = 4'hC;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_IRQ       = 3;
  localparam int ST_COUNT_LSB = 4;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_e;

  // STATUS only has a 4-bit count field; deeper FIFOs saturate at 15.
  function automatic logic [3:0] clip_count(input logic [31:0] cnt);
    return (cnt > 32'd15) ? 4'hF : cnt[3:0];
  endfunction

endpackage

// File: rtl/mips_mem_responder_if.sv
// Unified core memory bus plus the output-FIFO valid/ready stream.
// master = core/consumer side, slave = memory responder.
interface mips_mem_responder_if;

  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ena;
  logic [31:0] mem_rd_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output mem_addr,
    output mem_wr_data,
    output mem_wr_ena,
    output out_ready,
    input  mem_rd_data,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  mem_addr,
    input  mem_wr_data,
    input  mem_wr_ena,
    input  out_ready,
    output mem_rd_data,
    output out_data,
    output out_valid
  );

endinterface

// File: rtl/resp_out_fifo.sv
// Circular output FIFO (power-of-2 depth). Head word is read from the storage
// registers and forced to zero while empty; a pop frees a slot for a same-cycle push.
module resp_out_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 32
) (
  input  logic                        clk,
  input  logic                        rstb,
  input  logic                        i_push,
  input  logic                        i_pop,
  input  logic [DATA_W-1:0]           i_data,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [$clog2(FIFO_DEPTH):0] o_count,
  output logic [DATA_W-1:0]           o_head
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == DEPTH_C);
  assign o_count = r_count;
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/mips_mem_responder.sv
// Memory responder for the multicycle MIPS core: word RAM plus MMIO cycle counter,
// compare timer and output FIFO. Optional MIPS_MEM_TEXT_WP_EN write-protects the text region.
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int          MEM_WORDS  = 256,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 4
`ifdef MIPS_MEM_TEXT_WP_EN
  ,
  parameter int          TEXT_WORDS = 64
`endif
) (
  input  logic                clk,
  input  logic                rstb,
  mips_mem_responder_if.slave bus,
  output logic                timer_irq,
  output logic                addr_err
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   r_ram [MEM_WORDS];
  logic [31:0]   r_cycle;
  logic [31:0]   r_cmp;
  logic          r_irq;
  logic          r_ovf;
  logic          r_err;

  logic [29:0]   w_word_idx;
  logic [AW-1:0] w_ram_idx;
  logic [3:0]    w_mmio_off;
  region_e       w_region;
  logic          w_misaligned;
  logic          w_wr;
  logic          w_wp_block;
  logic          w_ram_we;
  logic          w_mmio_we;
  logic          w_cycle_we;
  logic          w_out_we;
  logic          w_status_we;
  logic          w_cmp_we;
  logic          w_err_set;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_ovf_set;
  logic [CW-1:0] w_count;
  logic [31:0]   w_head;
  logic [31:0]   w_status;

  assign w_word_idx   = bus.mem_addr[31:2];
  assign w_ram_idx    = bus.mem_addr[AW+1:2];
  assign w_mmio_off   = {bus.mem_addr[3:2], 2'b00};
  assign w_misaligned = |bus.mem_addr[1:0];

  always_comb begin
    if (w_word_idx < 30'(MEM_WORDS))
      w_region = REG_RAM;
    else if (bus.mem_addr[31:4] == MMIO_BASE[31:4])
      w_region = REG_MMIO;
    else
      w_region = REG_NONE;
  end

`ifdef MIPS_MEM_TEXT_WP_EN
  assign w_wp_block = (w_word_idx < 30'(TEXT_WORDS));
`else
  assign w_wp_block = 1'b0;
`endif

  // Misaligned stores are dropped everywhere; only aligned ones reach RAM/MMIO.
  assign w_wr        = bus.mem_wr_ena && !w_misaligned;
  assign w_ram_we    = w_wr && (w_region == REG_RAM) && !w_wp_block;
  assign w_mmio_we   = w_wr && (w_region == REG_MMIO);
  assign w_cycle_we  = w_mmio_we && (w_mmio_off == MMIO_CYCLE);
  assign w_out_we    = w_mmio_we && (w_mmio_off == MMIO_OUT);
  assign w_status_we = w_mmio_we && (w_mmio_off == MMIO_STATUS);
  assign w_cmp_we    = w_mmio_we && (w_mmio_off == MMIO_CMP);

  // Unmapped reads are legal because the core always drives some address.
  assign w_err_set = w_misaligned
                   || (bus.mem_wr_ena && (w_region == REG_NONE))
                   || (w_wr && (w_region == REG_RAM) && w_wp_block);

  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[w_ram_idx] <= bus.mem_wr_data;
  end

  assign w_pop     = !w_empty && bus.out_ready;
  assign w_ovf_set = w_out_we && w_full && !w_pop;

  resp_out_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (32)
  ) u_fifo (
    .clk     (clk),
    .rstb    (rstb),
    .i_push  (w_out_we),
    .i_pop   (w_pop),
    .i_data  (bus.mem_wr_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

  always_comb begin
    w_status                    = '0;
    w_status[ST_EMPTY]          = w_empty;
    w_status[ST_FULL]           = w_full;
    w_status[ST_OVF]            = r_ovf;
    w_status[ST_IRQ]            = r_irq;
    w_status[ST_COUNT_LSB +: 4] = clip_count(32'(w_count));
  end

  always_comb begin
    bus.mem_rd_data = '0;
    case (w_region)
      REG_RAM: bus.mem_rd_data = r_ram[w_ram_idx];
      REG_MMIO: begin
        case (w_mmio_off)
          MMIO_CYCLE:  bus.mem_rd_data = r_cycle;
          MMIO_OUT:    bus.mem_rd_data = w_head;
          MMIO_STATUS: bus.mem_rd_data = w_status;
          MMIO_CMP:    bus.mem_rd_data = r_cmp;
          default:     bus.mem_rd_data = '0;
        endcase
      end
      default: bus.mem_rd_data = '0;
    endcase
  end

  // Sticky flags: a set event in the same cycle as a software clear wins.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_cycle <= '0;
      r_cmp   <= 32'hFFFF_FFFF;
      r_irq   <= 1'b0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_cycle <= w_cycle_we ? bus.mem_wr_data : r_cycle + 32'd1;
      if (w_cmp_we) r_cmp <= bus.mem_wr_data;
      if (r_cycle == r_cmp)
        r_irq <= 1'b1;
      else if (w_status_we && bus.mem_wr_data[ST_IRQ])
        r_irq <= 1'b0;
      if (w_ovf_set)
        r_ovf <= 1'b1;
      else if (w_status_we && bus.mem_wr_data[ST_OVF])
        r_ovf <= 1'b0;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign bus.out_data  = w_head;
  assign bus.out_valid = !w_empty;
  assign timer_irq     = r_irq;
  assign addr_err      = r_err;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Self-checking bench for mips_mem_responder: vector table for RAM/MMIO reads,
// FIFO scoreboard queue, and hand sequences for timer, overflow and async reset.
module tb_mips_mem_responder;

  localparam logic [31:0] MMIO = 32'hFFFF_0000;
`ifdef MIPS_MEM_TEXT_WP_EN
  localparam logic [31:0] TEST_ADDR = 32'h0000_0110;
`else
  localparam logic [31:0] TEST_ADDR = 32'h0000_0010;
`endif

  logic clk = 1'b0;
  logic rstb;
  logic timer_irq;
  logic addr_err;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] expQ[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];
  logic [31:0] pushData[5];

  mips_mem_responder_if bus();

  mips_mem_responder dut (
    .clk       (clk),
    .rstb      (rstb),
    .bus       (bus),
    .timer_irq (timer_irq),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [31:0] wdata, input logic ready);
    @(posedge clk);
    #2;
    bus.mem_addr    = addr;
    bus.mem_wr_ena  = we;
    bus.mem_wr_data = wdata;
    bus.out_ready   = ready;
  endtask

  task automatic drainFifo(input string name);
    for (int i = 0; i < 20 && expQ.size() != 0; i++) begin
      applyStimulus(MMIO + 32'h8, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
    end
    checkOutput(name, 32'(expQ.size()), 32'h0);
    applyStimulus(MMIO + 32'h8, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
  endtask

  task automatic resetPulse();
    @(posedge clk);
    #3;
    rstb = 1'b0;
    #2;
    rstb = 1'b1;
  endtask

  // Scoreboard: every pop seen on the stream must match the oldest accepted push.
  always @(negedge clk) begin
    if (rstb && bus.out_valid && bus.out_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pop: got %h, expected no pop", bus.out_data);
      end else begin
        checkOutput("fifo_pop_data", bus.out_data, expQ.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, TEST_ADDR,       32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, TEST_ADDR,       32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_03FC,   32'hA5A5_0001, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0200,   32'h0123_4567, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_03FC,   32'h0,         1'b1, 32'hA5A5_0001};
    vecs[5]  = '{1'b0, 32'h0000_0200,   32'h0,         1'b1, 32'h0123_4567};
    vecs[6]  = '{1'b0, 32'h0000_0400,   32'h0,         1'b1, 32'h0};
    vecs[7]  = '{1'b0, MMIO + 32'hC,    32'h0,         1'b1, 32'hFFFF_FFFF};
    vecs[8]  = '{1'b1, MMIO + 32'hC,    32'h8000_0000, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, MMIO + 32'hC,    32'h0,         1'b1, 32'h8000_0000};
    vecs[10] = '{1'b0, MMIO + 32'h8,    32'h0,         1'b1, 32'h0000_0001};
    vecs[11] = '{1'b0, MMIO + 32'h4,    32'h0,         1'b1, 32'h0};
    vecs[12] = '{1'b1, 32'h0000_0200,   32'hCAFE_F00D, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 32'h0000_0200,   32'h0,         1'b1, 32'hCAFE_F00D};
    vecs[14] = '{1'b0, 32'h7FFF_FFFC,   32'h0,         1'b1, 32'h0};
    pushData[0] = 32'h1111_0000;
    pushData[1] = 32'h2222_0001;
    pushData[2] = 32'h3333_0002;
    pushData[3] = 32'h4444_0003;
    pushData[4] = 32'h5555_0004;

    rstb            = 1'b1;
    bus.mem_addr    = MMIO + 32'h8;
    bus.mem_wr_ena  = 1'b0;
    bus.mem_wr_data = 32'h0;
    bus.out_ready   = 1'b0;
    #1;
    rstb = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("reset_out_data", bus.out_data, 32'h0);
    checkOutput("reset_timer_irq", 32'(timer_irq), 32'h0);
    checkOutput("reset_addr_err", 32'(addr_err), 32'h0);
    checkOutput("reset_status", bus.mem_rd_data, 32'h0000_0001);
    rstb = 1'b1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].we, vecs[i].wdata, 1'b0);
      @(negedge clk);
      if (vecs[i].chk) checkOutput($sformatf("vec%0d_rd", i), bus.mem_rd_data, vecs[i].exp);
    end
    applyStimulus(TEST_ADDR, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("no_err_after_table", 32'(addr_err), 32'h0);

    // Misaligned read: data ignores low bits, error flag appears after the edge.
    applyStimulus(TEST_ADDR + 32'h2, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("misaligned_rd", bus.mem_rd_data, 32'hDEAD_BEEF);
    checkOutput("misaligned_err_pre", 32'(addr_err), 32'h0);
    applyStimulus(32'h0000_0202, 1'b1, 32'h0000_0BAD, 1'b0);
    @(negedge clk);
    checkOutput("misaligned_err_set", 32'(addr_err), 32'h1);
    applyStimulus(32'h0000_0200, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("misaligned_wr_dropped", bus.mem_rd_data, 32'hCAFE_F00D);

    // Fill past capacity with the consumer stalled.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(MMIO + 32'h4, 1'b1, pushData[i], 1'b0);
      if (i < 4) expQ.push_back(pushData[i]);
    end
    applyStimulus(MMIO + 32'h8, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("status_full_ovf", bus.mem_rd_data, 32'h0000_0046);
    checkOutput("head_after_fill", bus.out_data, pushData[0]);
    applyStimulus(MMIO + 32'h4, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("peek_no_pop", bus.mem_rd_data, pushData[0]);
    applyStimulus(MMIO + 32'h8, 1'b1, 32'h0000_0004, 1'b0);
    applyStimulus(MMIO + 32'h4, 1'b1, 32'h6666_0005, 1'b1);
    expQ.push_back(32'h6666_0005);
    applyStimulus(MMIO + 32'h8, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("status_full_pushpop", bus.mem_rd_data, 32'h0000_0042);
    drainFifo("drain1_timeout");
    checkOutput("drain1_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("drain1_status", bus.mem_rd_data, 32'h0000_0001);

    // Push and pop together with a single entry.
    applyStimulus(MMIO + 32'h4, 1'b1, 32'h7777_0001, 1'b0);
    expQ.push_back(32'h7777_0001);
    applyStimulus(MMIO + 32'h4, 1'b1, 32'h8888_0002, 1'b1);
    expQ.push_back(32'h8888_0002);
    applyStimulus(MMIO + 32'h8, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("one_pushpop_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("one_pushpop_head", bus.out_data, 32'h8888_0002);
    checkOutput("one_pushpop_status", bus.mem_rd_data, 32'h0000_0010);
    drainFifo("drain2_timeout");
    checkOutput("drain2_valid", 32'(bus.out_valid), 32'h0);

    // Counter wrap and compare match.
    applyStimulus(MMIO + 32'hC, 1'b1, 32'h0, 1'b0);
    applyStimulus(MMIO + 32'h0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    applyStimulus(MMIO + 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("cycle_loaded", bus.mem_rd_data, 32'hFFFF_FFFE);
    applyStimulus(MMIO + 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("cycle_max", bus.mem_rd_data, 32'hFFFF_FFFF);
    applyStimulus(MMIO + 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("cycle_wrapped", bus.mem_rd_data, 32'h0);
    checkOutput("irq_not_yet", 32'(timer_irq), 32'h0);
    applyStimulus(MMIO + 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("cycle_after_wrap", bus.mem_rd_data, 32'h1);
    checkOutput("irq_set", 32'(timer_irq), 32'h1);
    applyStimulus(MMIO + 32'h8, 1'b1, 32'h0000_0008, 1'b0);
    @(negedge clk);
    checkOutput("status_irq", bus.mem_rd_data, 32'h0000_0009);
    applyStimulus(MMIO + 32'h8, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("irq_cleared", 32'(timer_irq), 32'h0);
    checkOutput("status_irq_cleared", bus.mem_rd_data, 32'h0000_0001);

    resetPulse();
    applyStimulus(32'h8000_0000, 1'b1, 32'h0000_1234, 1'b0);
    @(negedge clk);
    checkOutput("unmapped_err_pre", 32'(addr_err), 32'h0);
    applyStimulus(32'h8000_0000, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("unmapped_err", 32'(addr_err), 32'h1);
    checkOutput("unmapped_rd", bus.mem_rd_data, 32'h0);

    resetPulse();
    applyStimulus(32'h0000_0000, 1'b1, 32'h55AA_55AA, 1'b0);
    applyStimulus(32'h0000_0000, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
`ifdef MIPS_MEM_TEXT_WP_EN
    checkOutput("text_wp_err", 32'(addr_err), 32'h1);
`else
    checkOutput("word0_rd", bus.mem_rd_data, 32'h55AA_55AA);
    checkOutput("word0_no_err", 32'(addr_err), 32'h0);
`endif

    // Build up state, then pull reset between clock edges.
    applyStimulus(MMIO + 32'h4, 1'b1, 32'h0000_0077, 1'b0);
    expQ.push_back(32'h0000_0077);
    applyStimulus(32'h8000_0004, 1'b1, 32'h0, 1'b0);
    applyStimulus(MMIO + 32'hC, 1'b1, 32'h7, 1'b0);
    applyStimulus(MMIO + 32'h0, 1'b1, 32'h5, 1'b0);
    repeat (4) applyStimulus(MMIO + 32'h8, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("pre_rst_irq", 32'(timer_irq), 32'h1);
    checkOutput("pre_rst_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("pre_rst_err", 32'(addr_err), 32'h1);
    #1;
    rstb = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("async_rst_data", bus.out_data, 32'h0);
    checkOutput("async_rst_irq", 32'(timer_irq), 32'h0);
    checkOutput("async_rst_err", 32'(addr_err), 32'h0);
    expQ.delete();
    applyStimulus(32'h0000_0200, 1'b0, 32'h0, 1'b0);
    rstb = 1'b1;
    @(negedge clk);
    checkOutput("ram_kept_200", bus.mem_rd_data, 32'hCAFE_F00D);
    applyStimulus(32'h0000_03FC, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("ram_kept_3fc", bus.mem_rd_data, 32'hA5A5_0001);
    applyStimulus(MMIO + 32'h8, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("post_rst_status", bus.mem_rd_data, 32'h0000_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
